alu_div_seq: RTL and testbench



---
 rtl/alu_div_seq_pkg.sv | 20 ++
 rtl/alu_div_seq_div_step.sv | 25 ++
 rtl/alu_div_seq.sv | 203 ++++++++++++++++++++
 tb/tb_alu_div_seq.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_div_seq_pkg.sv
// Shared types and constants for the iterative restoring divider alu_div_seq.
package alu_div_seq_pkg;

  localparam int unsigned W     = 8;
  localparam int unsigned CNT_W = $clog2(W);

  localparam logic [W-1:0] DIV0_QUOT = W'(8'hFF);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Two's-complement negate when neg is set, identity otherwise.
  function automatic logic [W-1:0] neg_if(input logic neg, input logic [W-1:0] v);
    return neg ? W'(~v + W'(1)) : v;
  endfunction

endpackage

// File: rtl/alu_div_seq_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module alu_div_seq_div_step
  import alu_div_seq_pkg::*;
(
  input  logic [W:0]   rem_i,
  input  logic [W-1:0] div_i,
  input  logic         bit_i,
  output logic [W:0]   rem_o,
  output logic         qbit_o
);

  logic [W:0] shifted_c;
  logic [W:0] diff_c;
  logic       carry_c;

  // Subtract as add of the inverted divisor with carry-in 1; carry-out means no borrow.
  // A set MSB shifted out of the remainder already guarantees the trial succeeds.
  always_comb begin
    shifted_c          = {rem_i[W-1:0], bit_i};
    {carry_c, diff_c}  = {1'b0, shifted_c} + {1'b0, ~{1'b0, div_i}} + (W+2)'(1);
    qbit_o             = carry_c | rem_i[W];
    rem_o              = qbit_o ? diff_c : shifted_c;
  end

endmodule

// File: rtl/alu_div_seq.sv
// Iterative 8-bit restoring divider with valid/ready handshakes, one quotient bit per cycle.
// Signed operation is added when ALU_DIV_SIGNED_EN is defined.
module alu_div_seq
  import alu_div_seq_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         io_in_valid,
  output logic         io_in_ready,
  input  logic [W-1:0] io_in_a,
  input  logic [W-1:0] io_in_b,
`ifdef ALU_DIV_SIGNED_EN
  input  logic         io_in_signed,
  output logic         io_out_overflow,
`endif
  output logic         io_out_valid,
  input  logic         io_out_ready,
  output logic [W-1:0] io_out_quot,
  output logic [W-1:0] io_out_rem,
  output logic         io_out_div_zero
);

  state_e             state_q, state_d;
  logic               ready_q, ready_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]       quot_q, quot_d;
  logic [W:0]         rem_q, rem_d;
  logic [W-1:0]       div_q, div_d;
  logic               dz_q, dz_d;
  logic               negq_q, negq_d;
  logic               negr_q, negr_d;
  logic [W-1:0]       oquot_q, oquot_d;
  logic [W-1:0]       orem_q, orem_d;
  logic               odz_q, odz_d;
`ifdef ALU_DIV_SIGNED_EN
  logic               ovf_q, ovf_d;
  logic               oovf_q, oovf_d;
`endif

  logic               sgn_c, a_neg_c, b_neg_c, accept_c;
  logic [W-1:0]       a_mag_c, b_mag_c;
  logic [W:0]         step_rem_c;
  logic               qbit_c;
  logic [W-1:0]       fin_quot_c, fin_rem_c;

  alu_div_seq_div_step u_div_step (
    .rem_i  (rem_q),
    .div_i  (div_q),
    .bit_i  (quot_q[W-1]),
    .rem_o  (step_rem_c),
    .qbit_o (qbit_c)
  );

`ifdef ALU_DIV_SIGNED_EN
  assign sgn_c = io_in_signed;
`else
  assign sgn_c = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      dz_q    <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      oquot_q <= '0;
      orem_q  <= '0;
      odz_q   <= 1'b0;
`ifdef ALU_DIV_SIGNED_EN
      ovf_q   <= 1'b0;
      oovf_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      dz_q    <= dz_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      oquot_q <= oquot_d;
      orem_q  <= orem_d;
      odz_q   <= odz_d;
`ifdef ALU_DIV_SIGNED_EN
      ovf_q   <= ovf_d;
      oovf_q  <= oovf_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    div_d    = div_q;
    dz_d     = dz_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    oquot_d  = oquot_q;
    orem_d   = orem_q;
    odz_d    = odz_q;
`ifdef ALU_DIV_SIGNED_EN
    ovf_d    = ovf_q;
    oovf_d   = oovf_q;
`endif

    accept_c = (state_q == ST_IDLE) && ready_q && io_in_valid;
    a_neg_c  = sgn_c & io_in_a[W-1];
    b_neg_c  = sgn_c & io_in_b[W-1];
    a_mag_c  = neg_if(a_neg_c, io_in_a);
    b_mag_c  = neg_if(b_neg_c, io_in_b);

    // Final magnitudes come from the last step while in BUSY, else from the held registers.
    fin_quot_c = (state_q == ST_BUSY) ? {quot_q[W-2:0], qbit_c} : quot_q;
    fin_rem_c  = (state_q == ST_BUSY) ? step_rem_c[W-1:0] : rem_q[W-1:0];

    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          quot_d = a_mag_c;
          div_d  = b_mag_c;
          rem_d  = '0;
          cnt_d  = '0;
          dz_d   = 1'b0;
          negq_d = a_neg_c ^ b_neg_c;
          negr_d = a_neg_c;
`ifdef ALU_DIV_SIGNED_EN
          ovf_d  = a_neg_c && b_neg_c && (io_in_a == {1'b1, {(W-1){1'b0}}})
                   && (io_in_b == {W{1'b1}});
`endif
          if (io_in_b == '0) begin
            state_d = ST_DONE;
            quot_d  = DIV0_QUOT;
            rem_d   = {1'b0, io_in_a};
            dz_d    = 1'b1;
            negq_d  = 1'b0;
            negr_d  = 1'b0;
`ifdef ALU_DIV_SIGNED_EN
            ovf_d   = 1'b0;
`endif
          end else begin
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        quot_d = {quot_q[W-2:0], qbit_c};
        rem_d  = step_rem_c;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(W-1)) begin
          state_d = ST_DONE;
          valid_d = 1'b1;
          oquot_d = neg_if(negq_q, fin_quot_c);
          orem_d  = neg_if(negr_q, fin_rem_c);
          odz_d   = dz_q;
`ifdef ALU_DIV_SIGNED_EN
          oovf_d  = ovf_q;
`endif
        end
      end
      ST_DONE: begin
        if (!valid_q) begin
          // Divide-by-zero arrives here straight from IDLE; publish one cycle later.
          valid_d = 1'b1;
          oquot_d = neg_if(negq_q, fin_quot_c);
          orem_d  = neg_if(negr_q, fin_rem_c);
          odz_d   = dz_q;
`ifdef ALU_DIV_SIGNED_EN
          oovf_d  = ovf_q;
`endif
        end else if (io_out_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  assign io_in_ready     = ready_q;
  assign io_out_valid    = valid_q;
  assign io_out_quot     = oquot_q;
  assign io_out_rem      = orem_q;
  assign io_out_div_zero = odz_q;
`ifdef ALU_DIV_SIGNED_EN
  assign io_out_overflow = oovf_q;
`endif

endmodule

// File: tb/tb_alu_div_seq.sv
// Scoreboard bench for alu_div_seq: expected results queued at acceptance, compared at output.
module tb_alu_div_seq;

  logic       clock;
  logic       reset;
  logic       io_in_valid;
  logic       io_in_ready;
  logic [7:0] io_in_a;
  logic [7:0] io_in_b;
  logic       io_out_valid;
  logic       io_out_ready;
  logic [7:0] io_out_quot;
  logic [7:0] io_out_rem;
  logic       io_out_div_zero;
`ifdef ALU_DIV_SIGNED_EN
  logic       io_in_signed;
  logic       io_out_overflow;
`endif

  typedef struct {
    logic [7:0] quot;
    logic [7:0] rem;
    logic       dz;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int   n_checks;
  int   n_errors;

  alu_div_seq dut (
    .clock           (clock),
    .reset           (reset),
    .io_in_valid     (io_in_valid),
    .io_in_ready     (io_in_ready),
    .io_in_a         (io_in_a),
    .io_in_b         (io_in_b),
`ifdef ALU_DIV_SIGNED_EN
    .io_in_signed    (io_in_signed),
    .io_out_overflow (io_out_overflow),
`endif
    .io_out_valid    (io_out_valid),
    .io_out_ready    (io_out_ready),
    .io_out_quot     (io_out_quot),
    .io_out_rem      (io_out_rem),
    .io_out_div_zero (io_out_div_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic sg);
    exp_t e;
    int   sa, sbv;
    e.dz  = (b == 8'd0);
    e.ovf = 1'b0;
    if (b == 8'd0) begin
      e.quot = 8'hFF;
      e.rem  = a;
    end else if (sg) begin
      sa     = int'($signed(a));
      sbv    = int'($signed(b));
      e.quot = 8'(sa / sbv);
      e.rem  = 8'(sa % sbv);
      e.ovf  = (a == 8'h80) && (b == 8'hFF);
    end else begin
      e.quot = a / b;
      e.rem  = a % b;
    end
    return e;
  endfunction

  // Wait (bounded) at a falling edge until the DUT is ready for operands.
  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clock);
    while (!io_in_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!io_in_ready) check_eq("in_ready_timeout", 32'(io_in_ready), 32'd1);
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic sg, input int hold);
    int   n;
    bit   got;
    exp_t e;
    wait_ready();
    io_in_valid = 1'b1;
    io_in_a     = a;
    io_in_b     = b;
`ifdef ALU_DIV_SIGNED_EN
    io_in_signed = sg;
`endif
    sb.push_back(model(a, b, sg));
    @(posedge clock);
    #1;
    io_in_valid = 1'b0;
    io_in_a     = 8'h00;
    io_in_b     = 8'h00;
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clock);
      n++;
      @(negedge clock);
      if (io_out_valid) got = 1'b1;
    end
    check_eq("latency", 32'(n), (b == 8'd0) ? 32'd1 : 32'd8);
    if (!got) begin
      void'(sb.pop_front());
      return;
    end
    // Backpressure: result must hold and no operands may be taken, even if offered.
    for (int i = 0; i < hold; i++) begin
      io_in_valid = 1'b1;
      io_in_a     = 8'h11;
      io_in_b     = 8'h03;
      check_eq("hold_quot", 32'(io_out_quot), 32'(sb[0].quot));
      check_eq("hold_rem", 32'(io_out_rem), 32'(sb[0].rem));
      check_eq("hold_in_ready", 32'(io_in_ready), 32'd0);
      check_eq("hold_valid", 32'(io_out_valid), 32'd1);
      @(negedge clock);
    end
    io_in_valid = 1'b0;
    e = sb.pop_front();
    check_eq("quot", 32'(io_out_quot), 32'(e.quot));
    check_eq("rem", 32'(io_out_rem), 32'(e.rem));
    check_eq("div_zero", 32'(io_out_div_zero), 32'(e.dz));
`ifdef ALU_DIV_SIGNED_EN
    check_eq("overflow", 32'(io_out_overflow), 32'(e.ovf));
`endif
    io_out_ready = 1'b1;
    @(posedge clock);
    #1;
    io_out_ready = 1'b0;
    check_eq("post_hs_valid", 32'(io_out_valid), 32'd0);
    check_eq("post_hs_ready", 32'(io_in_ready), 32'd1);
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rs;
    n_checks     = 0;
    n_errors     = 0;
    reset        = 1'b1;
    io_in_valid  = 1'b0;
    io_in_a      = 8'h00;
    io_in_b      = 8'h00;
    io_out_ready = 1'b0;
`ifdef ALU_DIV_SIGNED_EN
    io_in_signed = 1'b0;
`endif

    repeat (2) @(posedge clock);
    @(negedge clock);
    check_eq("rst_in_ready", 32'(io_in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(io_out_valid), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check_eq("rst_ready_after", 32'(io_in_ready), 32'd1);
    check_eq("rst_quot", 32'(io_out_quot), 32'd0);
    check_eq("rst_rem", 32'(io_out_rem), 32'd0);
    check_eq("rst_dz", 32'(io_out_div_zero), 32'd0);

    do_op(8'd100, 8'd7, 1'b0, 0);
    do_op(8'd255, 8'd1, 1'b0, 0);
    do_op(8'd3, 8'd200, 1'b0, 0);
    do_op(8'd5, 8'd0, 1'b0, 0);
    do_op(8'd200, 8'd9, 1'b0, 5);
    do_op(8'd0, 8'd0, 1'b0, 1);
    do_op(8'd255, 8'd255, 1'b0, 0);

    // Reset while BUSY, in the cycle that would perform step 4.
    wait_ready();
    io_in_valid = 1'b1;
    io_in_a     = 8'd200;
    io_in_b     = 8'd3;
    @(posedge clock);
    #1;
    io_in_valid = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check_eq("midrst_valid", 32'(io_out_valid), 32'd0);
    check_eq("midrst_quot", 32'(io_out_quot), 32'd0);
    check_eq("midrst_rem", 32'(io_out_rem), 32'd0);
    check_eq("midrst_dz", 32'(io_out_div_zero), 32'd0);
    check_eq("midrst_in_ready", 32'(io_in_ready), 32'd0);
    reset = 1'b0;
    do_op(8'd50, 8'd5, 1'b0, 0);

`ifdef ALU_DIV_SIGNED_EN
    do_op(8'h9C, 8'd7, 1'b1, 0);
    do_op(8'h80, 8'hFF, 1'b1, 2);
    do_op(8'hF6, 8'h00, 1'b1, 0);
    do_op(8'd100, 8'hF9, 1'b1, 0);
`endif

    for (int i = 0; i < 16; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = (i % 5 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      rs = 1'b0;
`ifdef ALU_DIV_SIGNED_EN
      rs = 1'($urandom_range(0, 1));
`endif
      do_op(ra, rb, rs, i % 3);
    end

    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
